mcu_playlist: RTL

Parametrised successor to the four-song music control unit. Sequences playback over `NUM_SONGS` songs and drives the song player's `play`, `reset_player` and `song` inputs. Adds a previous button with restart-vs-back behaviour, selectable repeat modes, and a registered one-cycle `reset_player` pulse on every song change. Sits between the debounced/one-pulsed button logic and the song player.

---
 rtl/mcu_pkg.sv | 24 ++
 rtl/dffr.sv | 25 ++
 rtl/mcu_playlist.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// ============================================================================
// Module      : mcu_pkg
// Description : Shared state encodings and repeat-mode constants for the
//               music control unit playlist sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcu_pkg;

    // One-hot playback states
    localparam logic [3:0] ST_STOPPED = 4'b0001;
    localparam logic [3:0] ST_PLAYING = 4'b0010;
    localparam logic [3:0] ST_PAUSED  = 4'b0100;
    localparam logic [3:0] ST_SWITCH  = 4'b1000;

    // Repeat modes; the unused encoding 3 behaves like RPT_ALL
    localparam logic [1:0] RPT_ALL  = 2'd0;
    localparam logic [1:0] RPT_ONE  = 2'd1;
    localparam logic [1:0] RPT_STOP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dffr.sv
// ============================================================================
// Module      : dffr
// Description : Parametrised register with synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dffr #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (rst) o_q <= RST_VAL;
        else     o_q <= i_d;
    end

endmodule

`default_nettype wire

// File: rtl/mcu_playlist.sv
// ============================================================================
// Module      : mcu_playlist
// Description : Playlist sequencer driving the song player's play,
//               reset_player and song inputs from one-pulsed buttons.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_playlist
    import mcu_pkg::*;
#(
    parameter int NUM_SONGS      = 4,
    parameter int SONG_W         = $clog2(NUM_SONGS),
    parameter int RESTART_CYCLES = 48_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic [1:0]        repeat_mode,
    input  logic              song_done,
    output logic              play,
    output logic              reset_player,
    output logic [SONG_W-1:0] song
);

    localparam int                CNT_W       = $clog2(RESTART_CYCLES + 1);
    localparam logic [SONG_W-1:0] c_last_song = SONG_W'(NUM_SONGS - 1);
    localparam logic [CNT_W-1:0]  c_restart   = CNT_W'(RESTART_CYCLES);

    logic [3:0]        r_state,   w_state_d;
    logic [3:0]        r_target,  w_target_d;
    logic [SONG_W-1:0] r_song,    w_song_d;
    logic [CNT_W-1:0]  r_elapsed, w_elapsed_d;

    logic              w_skip_fwd;
    logic              w_skip_back;
    logic [SONG_W-1:0] w_song_inc;
    logic [SONG_W-1:0] w_song_dec;

    // Simultaneous next and prev cancel each other out
    assign w_skip_fwd  = next_button & ~prev_button;
    assign w_skip_back = prev_button & ~next_button;

    assign w_song_inc = (r_song == c_last_song) ? '0 : r_song + SONG_W'(1);
    assign w_song_dec = (r_song == '0) ? c_last_song : r_song - SONG_W'(1);

    always_comb begin
        w_state_d  = r_state;
        w_target_d = r_target;
        w_song_d   = r_song;
        case (r_state)
            ST_SWITCH: begin
                w_state_d = r_target;
            end
            ST_STOPPED, ST_PLAYING, ST_PAUSED: begin
                if (w_skip_fwd || w_skip_back) begin
                    w_state_d  = ST_SWITCH;
                    w_target_d = (r_state == ST_PLAYING) ? ST_PLAYING : ST_STOPPED;
                    if (w_skip_fwd)
                        w_song_d = w_song_inc;
                    else if (r_elapsed < c_restart)
                        w_song_d = w_song_dec;
                end else if (play_button) begin
                    w_state_d = (r_state == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
                end else if (song_done && (r_state == ST_PLAYING)) begin
                    w_state_d  = ST_SWITCH;
                    w_target_d = ST_PLAYING;
                    case (repeat_mode)
                        RPT_ONE: w_song_d = r_song;
                        RPT_STOP: begin
                            if (r_song == c_last_song) begin
                                w_song_d   = '0;
                                w_target_d = ST_STOPPED;
                            end else begin
                                w_song_d = w_song_inc;
                            end
                        end
                        RPT_ALL: w_song_d = w_song_inc;
                        default: w_song_d = w_song_inc;
                    endcase
                end
            end
            default: begin
                w_state_d  = ST_STOPPED;
                w_target_d = ST_STOPPED;
            end
        endcase
    end

    // Elapsed play time: advances only while playing, held across a pause
    always_comb begin
        w_elapsed_d = '0;
        case (r_state)
            ST_PLAYING: w_elapsed_d = (r_elapsed >= c_restart) ? c_restart
                                                               : r_elapsed + CNT_W'(1);
            ST_PAUSED:  w_elapsed_d = r_elapsed;
            default:    w_elapsed_d = '0;
        endcase
    end

    dffr #(.WIDTH(4), .RST_VAL(ST_STOPPED)) u_state (
        .clk(clk), .rst(reset), .i_d(w_state_d), .o_q(r_state)
    );

    dffr #(.WIDTH(4), .RST_VAL(ST_STOPPED)) u_target (
        .clk(clk), .rst(reset), .i_d(w_target_d), .o_q(r_target)
    );

    dffr #(.WIDTH(SONG_W), .RST_VAL('0)) u_song (
        .clk(clk), .rst(reset), .i_d(w_song_d), .o_q(r_song)
    );

    dffr #(.WIDTH(CNT_W), .RST_VAL('0)) u_elapsed (
        .clk(clk), .rst(reset), .i_d(w_elapsed_d), .o_q(r_elapsed)
    );

    // Outputs are registered from the next state so they align with r_state
    dffr #(.WIDTH(1), .RST_VAL(1'b0)) u_play (
        .clk(clk), .rst(reset), .i_d(w_state_d == ST_PLAYING), .o_q(play)
    );

    dffr #(.WIDTH(1), .RST_VAL(1'b0)) u_reset_player (
        .clk(clk), .rst(reset), .i_d(w_state_d == ST_SWITCH), .o_q(reset_player)
    );

    assign song = r_song;

endmodule

`default_nettype wire
